// File: rtl/fsk_pkg.sv
// Shared types, widths and the per-symbol frequency tuning words of the 16-FSK transmitter.
// No logic of its own; latency not applicable.
// No flow control; consumers apply their own backpressure.
package fsk_pkg;
    localparam int SYM_W   = 4;
    localparam int SAMP_W  = 17;
    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 10;

    typedef enum logic [1:0] {IDLE, SYNC, SYMBOL} state_t;

    // Symbol k sits at (k+1) MHz with Fs = 100 MHz: (k+1) * round(2^32/100), modulo 2^32.
    function automatic logic [PHASE_W-1:0] ftw(input logic [SYM_W-1:0] k);
        logic [63:0] p;
        p = (64'(k) + 64'd1) * 64'd42949673;
        return p[PHASE_W-1:0];
    endfunction
endpackage

// File: rtl/fsk_modulator_if.sv
// Symbol input handshake and DAC-side outputs of the FSK modulator.
// Pure wiring; no latency.
// sym_valid/sym_ready handshake; the output side is never stalled.
interface fsk_modulator_if;
    import fsk_pkg::*;

    logic                     tx_enable;
    logic [SYM_W-1:0]         sym_in;
    logic                     sym_valid;
    logic                     sym_ready;
    logic signed [SAMP_W-1:0] dac_out_sin;
    logic signed [SAMP_W-1:0] dac_out_cos;
    logic                     tx_active;
    logic                     frame_start;
    logic                     underrun;

    modport master (
        output tx_enable, sym_in, sym_valid,
        input  sym_ready, dac_out_sin, dac_out_cos, tx_active, frame_start, underrun
    );
    modport slave (
        input  tx_enable, sym_in, sym_valid,
        output sym_ready, dac_out_sin, dac_out_cos, tx_active, frame_start, underrun
    );
endinterface

// File: rtl/fsk_nco_lut.sv
// Quarter-offset sine ROM: one table, two read ports giving AMP*sin and AMP*cos of the phase index.
// 1-cycle latency (registered read).
// No backpressure; a new index is accepted every cycle.
module fsk_nco_lut
    import fsk_pkg::*;
#(
    parameter int AMP = 30000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LUT_AW-1:0]        idx,
    output logic signed [SAMP_W-1:0] sin_q,
    output logic signed [SAMP_W-1:0] cos_q
);
    localparam int DEPTH = 1 << LUT_AW;

    // Round-half-away-from-zero of AMP*sin(2*pi*i/DEPTH).
    function automatic logic signed [15:0] rom_entry(input int i, input int amp);
        real r;
        int  v;
        r = real'(amp) * $sin(2.0 * 3.14159265358979 * real'(i) / real'(DEPTH));
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        return 16'(v);
    endfunction

    logic signed [15:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = rom_entry(i, AMP);
    end

    // cos(x) = sin(x + pi/2): a quarter-table offset, wrapping naturally in LUT_AW bits.
    logic [LUT_AW-1:0] cos_idx;
    assign cos_idx = idx + LUT_AW'(DEPTH / 4);

    // Registered read of both ports, sign-extended to the DAC width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            sin_q <= SAMP_W'(rom[idx]);
            cos_q <= SAMP_W'(rom[cos_idx]);
        end
    end
endmodule

// File: rtl/fsk_modulator.sv
// 16-FSK transmitter: sync preamble then back-to-back phase-coherent I/Q tones, one per symbol.
// 2-cycle latency from state/phase to dac outputs; sym_ready and tx_active are combinational.
// One-entry holding register; sym_ready drops while it is full and not being consumed.
module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int                       SYM_LEN    = 100,
    parameter int                       SYNC_LEN   = 9,
    parameter logic signed [SAMP_W-1:0] SYNC_LEVEL = 17'sd1000,
    parameter int                       AMP        = 30000,
    parameter logic [SYM_W-1:0]         FILL_SYM   = 4'd0
) (
    input  logic           clk,
    input  logic           reset,
    fsk_modulator_if.slave bus
);
    localparam int CNT_W = $clog2(SYM_LEN);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [PHASE_W-1:0]  phase;
    logic [SYM_W-1:0]    cur_sym;
    logic                cur_fill;
    logic                hold_full;
    logic [SYM_W-1:0]    hold_sym;

    logic sync_last, sym_last, consume, sym_rdy, load;

    assign sync_last = (state == SYNC)   && (cnt == CNT_W'(SYNC_LEN - 1));
    assign sym_last  = (state == SYMBOL) && (cnt == CNT_W'(SYM_LEN - 1));
    // A frame end with tx_enable low leaves the held symbol for the next start.
    assign consume   = sync_last || (sym_last && bus.tx_enable && hold_full);
    assign sym_rdy   = !hold_full || consume;
    assign load      = bus.sym_valid && sym_rdy;

    // Holding register: a load in the consume cycle simply replaces the outgoing symbol.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_sym  <= '0;
        end else if (load) begin
            hold_full <= 1'b1;
            hold_sym  <= bus.sym_in;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    // Framing FSM and NCO: phase is n*FTW during sample n, restarting at 0 for every frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            phase    <= '0;
            cur_sym  <= '0;
            cur_fill <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    phase <= '0;
                    if (bus.tx_enable && hold_full) state <= SYNC;
                end
                SYNC: begin
                    if (sync_last) begin
                        state    <= SYMBOL;
                        cnt      <= '0;
                        phase    <= '0;
                        cur_sym  <= hold_sym;
                        cur_fill <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SYMBOL: begin
                    if (sym_last) begin
                        cnt   <= '0;
                        phase <= '0;
                        if (!bus.tx_enable) begin
                            state <= IDLE;
                        end else if (hold_full) begin
                            cur_sym  <= hold_sym;
                            cur_fill <= 1'b0;
                        end else begin
                            cur_sym  <= FILL_SYM;
                            cur_fill <= 1'b1;
                        end
                    end else begin
                        cnt   <= cnt + 1'b1;
                        phase <= phase + ftw(cur_sym);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic signed [SAMP_W-1:0] lut_sin, lut_cos;

    fsk_nco_lut #(.AMP(AMP)) u_lut (
        .clk   (clk),
        .reset (reset),
        .idx   (phase[PHASE_W-1 -: LUT_AW]),
        .sin_q (lut_sin),
        .cos_q (lut_cos)
    );

    logic s1_tone, s1_sync, s1_fs, s1_ur;

    // Stage 1: delay the sample kind and frame markers alongside the LUT read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_tone <= 1'b0;
            s1_sync <= 1'b0;
            s1_fs   <= 1'b0;
            s1_ur   <= 1'b0;
        end else begin
            s1_tone <= (state == SYMBOL);
            s1_sync <= (state == SYNC);
            s1_fs   <= (state == SYMBOL) && (cnt == '0);
            s1_ur   <= (state == SYMBOL) && (cnt == '0) && cur_fill;
        end
    end

    logic signed [SAMP_W-1:0] dac_sin, dac_cos;
    logic                     fs_q, ur_q;

    // Stage 2: select tone / preamble / silence; cos stays 0 outside tones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dac_sin <= '0;
            dac_cos <= '0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            dac_sin <= s1_tone ? lut_sin : (s1_sync ? SYNC_LEVEL : '0);
            dac_cos <= s1_tone ? lut_cos : '0;
            fs_q    <= s1_fs;
            ur_q    <= s1_ur;
        end
    end

    assign bus.sym_ready   = sym_rdy;
    assign bus.tx_active   = (state != IDLE);
    assign bus.dac_out_sin = dac_sin;
    assign bus.dac_out_cos = dac_cos;
    assign bus.frame_start = fs_q;
    assign bus.underrun    = ur_q;
endmodule

// File: tb/tb_fsk_modulator.sv
// Bench for fsk_modulator: per-cycle comparison against a frame-queue reference model,
// a table of hand-computed samples for the first frames, and randomized traffic with resets.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_fsk_modulator;
    import fsk_pkg::*;

    localparam real PI = 3.14159265358979;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fsk_modulator_if bus();

    fsk_modulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int s; int c; bit fs; bit ur; bit pre; } samp_t;
    typedef struct { string name; int idx; int s; int c; bit fs; bit ur; } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of samples still to emit, and the one-entry hold.
    samp_t      q[$];
    samp_t      mo[$];          // state-level sample per cycle, seen on the DAC two cycles later
    bit         m_full;
    logic [3:0] m_sym;
    int         k;

    int cap_s[$];
    int cap_c[$];
    bit cap_fs[$];
    bit cap_ur[$];

    logic [3:0] feed[$];
    bit         gate;
    bit         en;

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One frame: sample n has phase n*(sym+1)*42949673 mod 2^32; top 10 bits pick the angle.
    function automatic void push_frame(input logic [3:0] sym, input bit fill);
        for (int n = 0; n < 100; n++) begin
            longint ph;
            int     idx;
            samp_t  e;
            ph    = (longint'(n) * (longint'(sym) + 1) * 64'd42949673) % 64'h1_0000_0000;
            idx   = int'(ph >>> 22);
            e.s   = rnd(30000.0 * $sin(2.0 * PI * real'(idx) / 1024.0));
            e.c   = rnd(30000.0 * $cos(2.0 * PI * real'(idx) / 1024.0));
            e.fs  = (n == 0);
            e.ur  = (n == 0) && fill;
            e.pre = 1'b0;
            q.push_back(e);
        end
    endfunction

    function automatic void push_pre();
        for (int n = 0; n < 9; n++) q.push_back('{1000, 0, 1'b0, 1'b0, 1'b1});
    endfunction

    // Check the current cycle against the model, advance the model, then clock.
    task automatic step();
        samp_t cur;
        bit    act, last, rdy, ld, ok;
        samp_t ex;
        bus.tx_enable = en;
        bus.sym_valid = gate && (feed.size() > 0);
        bus.sym_in    = (feed.size() > 0) ? feed[0] : 4'd0;
        act  = (q.size() > 0);
        cur  = act ? q[0] : '{0, 0, 1'b0, 1'b0, 1'b0};
        last = (q.size() == 1);
        rdy  = !m_full || (last && (cur.pre || en));
        ld   = bus.sym_valid && rdy;
        mo.push_back(cur);
        ex   = (k >= 2) ? mo[k-2] : '{0, 0, 1'b0, 1'b0, 1'b0};
        ok = (iabs(int'(bus.dac_out_sin) - ex.s) <= 1) && (iabs(int'(bus.dac_out_cos) - ex.c) <= 1) &&
             (bus.frame_start == ex.fs) && (bus.underrun == ex.ur) &&
             (bus.tx_active == act) && (bus.sym_ready == rdy);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cycle_%0d: sin %0d want %0d, cos %0d want %0d, fs %0b want %0b, ur %0b want %0b, act %0b want %0b, rdy %0b want %0b",
                     k, bus.dac_out_sin, ex.s, bus.dac_out_cos, ex.c, bus.frame_start, ex.fs,
                     bus.underrun, ex.ur, bus.tx_active, act, bus.sym_ready, rdy);
        end
        cap_s.push_back(int'(bus.dac_out_sin));
        cap_c.push_back(int'(bus.dac_out_cos));
        cap_fs.push_back(bus.frame_start);
        cap_ur.push_back(bus.underrun);
        if (act) begin
            cur = q.pop_front();
            if (last) begin
                if (cur.pre) begin
                    push_frame(m_sym, 1'b0);
                    m_full = 1'b0;
                end else if (en) begin
                    if (m_full) begin
                        push_frame(m_sym, 1'b0);
                        m_full = 1'b0;
                    end else begin
                        push_frame(4'd0, 1'b1);
                    end
                end
            end
        end else if (en && m_full) begin
            push_pre();
        end
        if (ld) begin
            m_full = 1'b1;
            m_sym  = bus.sym_in;
            void'(feed.pop_front());
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.dac_out_sin != 0 || bus.dac_out_cos != 0 || bus.frame_start || bus.underrun || bus.tx_active) begin
            n_fail++;
            $display("FAIL async_reset: sin %0d cos %0d fs %0b ur %0b act %0b, want all 0",
                     bus.dac_out_sin, bus.dac_out_cos, bus.frame_start, bus.underrun, bus.tx_active);
        end
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        q.delete();
        mo.delete();
        cap_s.delete();
        cap_c.delete();
        cap_fs.delete();
        cap_ur.delete();
        m_full = 1'b0;
        m_sym  = 4'd0;
        k      = 0;
    endtask

    task automatic wait_cnt(input int remaining, input string name);
        for (int j = 0; j < 400 && !(q.size() == remaining && !q[0].pre); j++) step();
        n_chk++;
        if (!(q.size() == remaining && !q[0].pre)) begin
            n_fail++;
            $display("FAIL %s: queue depth %0d, want %0d inside a tone frame", name, q.size(), remaining);
        end
    endtask

    vec_t vecs[10];
    int   origin;

    initial begin
        en            = 1'b0;
        gate          = 1'b0;
        bus.tx_enable = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_in    = 4'd0;

        // Samples of a symbol-3 frame and the fill frame behind it, offsets from the first preamble sample.
        vecs = '{
            '{"pre_before", -1,     0,     0, 1'b0, 1'b0},
            '{"pre_first",   0,  1000,     0, 1'b0, 1'b0},
            '{"pre_last",    8,  1000,     0, 1'b0, 1'b0},
            '{"tone_s0",     9,     0, 30000, 1'b1, 1'b0},
            '{"tone_s1",    10,  7289, 29101, 1'b0, 1'b0},
            '{"tone_peak",  15, 29932,  2023, 1'b0, 1'b0},
            '{"tone_s25",   34,     0, 30000, 1'b0, 1'b0},
            '{"tone_s99",  108, -7468, 29056, 1'b0, 1'b0},
            '{"fill_s0",   109,     0, 30000, 1'b1, 1'b1},
            '{"fill_s1",   110,  1840, 29944, 1'b0, 1'b0}
        };

        #2;
        do_reset();

        // Idle: one symbol accepted, then held; nothing transmitted.
        feed = '{4'd5};
        gate = 1'b1;
        repeat (6) step();

        // Single symbol 3 then underrun into fill frames.
        #2;
        do_reset();
        feed = '{4'd3};
        step();
        en     = 1'b1;
        origin = k + 3;
        repeat (125) step();
        foreach (vecs[i]) begin
            int c;
            c = origin + vecs[i].idx;
            n_chk++;
            if (c < 0 || c >= cap_s.size()) begin
                n_fail++;
                $display("FAIL %s: sample %0d not captured", vecs[i].name, c);
            end else if (iabs(cap_s[c] - vecs[i].s) > 1 || iabs(cap_c[c] - vecs[i].c) > 1 ||
                         cap_fs[c] != vecs[i].fs || cap_ur[c] != vecs[i].ur) begin
                n_fail++;
                $display("FAIL %s: sin %0d cos %0d fs %0b ur %0b, want sin %0d cos %0d fs %0b ur %0b",
                         vecs[i].name, cap_s[c], cap_c[c], cap_fs[c], cap_ur[c],
                         vecs[i].s, vecs[i].c, vecs[i].fs, vecs[i].ur);
            end
        end
        en = 1'b0;
        repeat (110) step();

        // Back-to-back stream, then a lone symbol followed by starvation.
        feed = '{4'd0, 4'd15, 4'd7};
        en   = 1'b1;
        repeat (330) step();
        feed.push_back(4'd2);
        repeat (220) step();

        // Disable mid-frame at sample 40, then restart with a fresh preamble.
        wait_cnt(60, "reach_cnt40");
        en = 1'b0;
        repeat (150) step();
        feed.push_back(4'd9);
        en = 1'b1;
        repeat (150) step();

        // Randomized traffic with a reset landing at sample 50 of a frame.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en = !en;
            gate = ($urandom_range(0, 3) != 0);
            if (feed.size() < 3 && $urandom_range(0, 99) == 0) feed.push_back(4'($urandom_range(0, 15)));
            if (i == 1500) begin
                en   = 1'b1;
                gate = 1'b1;
                feed.push_back(4'($urandom_range(0, 15)));
                wait_cnt(50, "reach_cnt50");
                #2;
                do_reset();
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
